trig_counter_bank: RTL and testbench
====================================

Name: trig_counter_bank

Overview:
- Parametrised successor to the single up/down trigger counter: N_CH independent counters with per-channel modes (wrap, saturate, modulo, hold), synchronous load, and terminal-count pulses.
- A snapshot shadow bank captures all channels on the same edge. A registered word-read mux presents the snapshot as 16-bit words for WireOut endpoints.
- Coherent 32-bit reads over 16-bit wires are guaranteed.
- Sits between TriggerIn/WireIn endpoints (command and config source) and WireOut endpoints (readback), all in the clk1 domain.

Parameters:
- N_CH, 4, number of counter channels (1..16).
- WIDTH, 32, counter width in bits (2..64).
- WORDS, ceil(WIDTH/16), derived localparam; number of 16-bit read words per channel.

Ports:
- clk1  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ch_clear  in  N_CH  per-channel synchronous clear pulse.
- ch_load  in  N_CH  per-channel load pulse; loads load_value.
- load_value  in  WIDTH  shared load data.
- ch_up  in  N_CH  per-channel count-up pulse.
- ch_down  in  N_CH  per-channel count-down pulse.
- ch_mode  in  2*N_CH  per-channel mode; 00 wrap, 01 saturate, 10 modulo, 11 hold.
- ch_limit  in  WIDTH*N_CH  per-channel modulo limit, used only in mode 10.
- snap  in  1  snapshot capture pulse.
- rd_ch  in  4  channel select for readback.
- rd_word  in  3  16-bit word select; 0 = LSW.
- count  out  WIDTH*N_CH  live counter values; channel i is at [i*WIDTH +: WIDTH].
- tc_pulse  out  N_CH  one-cycle terminal-count pulse per channel.
- rd_data  out  16  selected snapshot word, registered.
- snap_seq  out  16  number of snapshots taken; wraps.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All counts, shadows, tc_pulse, rd_data and snap_seq go to 0 immediately.
  - All are held at 0 while reset_n is low; operation resumes on the first clk1 edge after release.
- Per-channel priority, evaluated each edge: clear > load > (up and down together) > up > down.
  - clear: count <= 0, no tc.
  - load: count <= load_value, no tc. Load is accepted in every mode, including hold, and even if load_value > limit.
  - up and down in the same cycle: no change, no tc.
  - Mode 11 (hold): up and down are ignored.
- Up step, per mode:
  - 00 wrap: count+1 modulo 2^WIDTH. tc=1 on the max→0 step.
  - 01 saturate: at all-ones, count holds and tc=1. Otherwise count+1.
  - 10 modulo: if count >= limit, count <= 0 and tc=1. Otherwise count+1.
- Down step, per mode:
  - 00 wrap: 0→all-ones with tc=1.
  - 01 saturate: holds at 0 with tc=1.
  - 10 modulo: at 0, count <= limit with tc=1. Otherwise count-1. A count above limit still decrements normally.
- Edge cases:
  - limit = 0 in modulo: every up or down step yields 0 with tc=1.
  - A mode change takes effect on the next step; the current count is not altered.
- tc_pulse and count update on the same edge. Latency is 1 cycle from the command pulse to both.
- Snapshot:
  - On an edge with snap=1, every shadow[i] captures the pre-edge count[i], i.e. the value before that edge's commands apply. snap_seq increments on the same edge.
- Read mux:
  - Each edge, rd_data <= shadow[rd_ch][rd_word*16 +: 16]. Read latency is 1 cycle from the rd_ch/rd_word change.
  - rd_ch >= N_CH or rd_word >= WORDS returns 0.
  - If WIDTH is not a multiple of 16, the top word is zero-extended.
- Shadow stability: shadow values never change except on snap or reset. A multi-word read sequence between snaps is therefore coherent.
- Commands are single-cycle pulses, as produced by okTriggerIn on clk1. A held input acts once per cycle.

Test Plan:
- Reset and clear: release reset_n. With no stimulus, count, rd_data and snap_seq are all 0. Assert reset_n low mid-count at count=5: count drops to 0 before the next edge.
- Wrap mode: load 0xFFFFFFFE on ch0, then two up pulses → counts 0xFFFFFFFF then 0x00000000, with tc_pulse[0]=1 only on the second step. Down pulse from 0 → 0xFFFFFFFF with tc=1.
- Saturate and hold:
  - ch1 mode 01, load 0xFFFFFFFF, up → stays 0xFFFFFFFF, tc=1.
  - ch1 at 0, down → stays 0, tc=1.
  - ch2 mode 11 at 7, up → stays 7; load 3 → 3.
- Modulo mode: ch3 limit 9, from 0, 10 up pulses → 1..9, then 0 with tc=1 on the 10th.
  - Down from 0 → 9 with tc=1.
  - Load 20, then up → 0 with tc=1.
- Priority: same cycle clear+load+up on ch0 → 0. Same cycle up+down at count 4 → 4, no tc. Load+up with load_value 100 → 100.
- Snapshot coherency:
  - ch0=0x0001FFFF; pulse snap together with up → shadow=0x0001FFFF, live count=0x00020000, snap_seq=1.
  - rd_word 0 then 1 → rd_data 0xFFFF, then 0x0001, each one cycle after the select.
  - rd_ch=N_CH → rd_data 0.

Source files
------------

// File: rtl/trig_counter_bank.sv
// trig_counter_bank: bank of N_CH independent trigger-driven counters with
// per-channel modes, a snapshot shadow bank and a registered 16-bit read mux.
//
// Ports:
//   clk1_i        system clock, rising edge
//   reset_n_i     asynchronous active-low reset
//   ch_clear_i    per-channel synchronous clear pulse
//   ch_load_i     per-channel load pulse (loads load_value_i)
//   load_value_i  shared load data
//   ch_up_i       per-channel count-up pulse
//   ch_down_i     per-channel count-down pulse
//   ch_mode_i     2 bits per channel: 00 wrap, 01 saturate, 10 modulo, 11 hold
//   ch_limit_i    WIDTH bits per channel, modulo limit (mode 10 only)
//   snap_i        snapshot capture pulse
//   rd_ch_i       readback channel select
//   rd_word_i     readback 16-bit word select, 0 = LSW
//   count_o       live counts, channel i at [i*WIDTH +: WIDTH]
//   tc_pulse_o    one-cycle terminal-count pulse per channel
//   rd_data_o     selected snapshot word, registered
//   snap_seq_o    number of snapshots taken, wraps
module trig_counter_bank #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk1_i,
    input  logic                    reset_n_i,
    input  logic [N_CH-1:0]         ch_clear_i,
    input  logic [N_CH-1:0]         ch_load_i,
    input  logic [WIDTH-1:0]        load_value_i,
    input  logic [N_CH-1:0]         ch_up_i,
    input  logic [N_CH-1:0]         ch_down_i,
    input  logic [2*N_CH-1:0]       ch_mode_i,
    input  logic [WIDTH*N_CH-1:0]   ch_limit_i,
    input  logic                    snap_i,
    input  logic [3:0]              rd_ch_i,
    input  logic [2:0]              rd_word_i,
    output logic [WIDTH*N_CH-1:0]   count_o,
    output logic [N_CH-1:0]         tc_pulse_o,
    output logic [15:0]             rd_data_o,
    output logic [15:0]             snap_seq_o
);

    localparam int unsigned WORDS = (WIDTH + 15) / 16;
    localparam int unsigned PadW  = WORDS * 16;

    typedef enum logic [1:0] {
        ModeWrap = 2'b00,
        ModeSat  = 2'b01,
        ModeMod  = 2'b10,
        ModeHold = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] One     = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q    [N_CH];
    logic [WIDTH-1:0] cnt_d    [N_CH];
    logic [WIDTH-1:0] shadow_q [N_CH];
    logic [N_CH-1:0]  tc_q, tc_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic [15:0]      snap_seq_q;

    // Per-channel next state: clear > load > (up and down) > up > down.
    always_comb begin
        mode_e            mode;
        logic [WIDTH-1:0] limit;
        mode  = ModeWrap;
        limit = '0;
        tc_d  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            mode     = mode_e'(ch_mode_i[2*i +: 2]);
            limit    = ch_limit_i[i*WIDTH +: WIDTH];
            if (ch_clear_i[i]) begin
                cnt_d[i] = '0;
            end else if (ch_load_i[i]) begin
                cnt_d[i] = load_value_i;
            end else if ((ch_up_i[i] && ch_down_i[i]) || mode == ModeHold) begin
                cnt_d[i] = cnt_q[i];
            end else if (ch_up_i[i]) begin
                unique case (mode)
                    ModeSat: begin
                        if (cnt_q[i] == AllOnes) tc_d[i] = 1'b1;
                        else                     cnt_d[i] = cnt_q[i] + One;
                    end
                    ModeMod: begin
                        if (cnt_q[i] >= limit) begin
                            cnt_d[i] = '0;
                            tc_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + One;
                        end
                    end
                    default: begin
                        cnt_d[i] = cnt_q[i] + One;
                        tc_d[i]  = (cnt_q[i] == AllOnes);
                    end
                endcase
            end else if (ch_down_i[i]) begin
                unique case (mode)
                    ModeSat: begin
                        if (cnt_q[i] == '0) tc_d[i] = 1'b1;
                        else                cnt_d[i] = cnt_q[i] - One;
                    end
                    ModeMod: begin
                        // Counts above limit still decrement; only 0 reloads.
                        if (cnt_q[i] == '0) begin
                            cnt_d[i] = limit;
                            tc_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] - One;
                        end
                    end
                    default: begin
                        cnt_d[i] = cnt_q[i] - One;
                        tc_d[i]  = (cnt_q[i] == '0);
                    end
                endcase
            end
        end
    end

    // Read mux over the shadow bank; out-of-range selects read as 0.
    always_comb begin
        logic [PadW-1:0] padded;
        padded    = '0;
        rd_data_d = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if ({28'd0, rd_ch_i} == c) padded[WIDTH-1:0] = shadow_q[c];
        end
        for (int unsigned w = 0; w < WORDS; w++) begin
            if ({29'd0, rd_word_i} == w) rd_data_d = padded[w*16 +: 16];
        end
    end

    always_ff @(posedge clk1_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            tc_q       <= '0;
            rd_data_q  <= '0;
            snap_seq_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                // Shadow takes the pre-edge count, before this edge's commands.
                if (snap_i) shadow_q[i] <= cnt_q[i];
            end
            tc_q      <= tc_d;
            rd_data_q <= rd_data_d;
            if (snap_i) snap_seq_q <= snap_seq_q + 16'd1;
        end
    end

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            count_o[i*WIDTH +: WIDTH] = cnt_q[i];
        end
    end

    assign tc_pulse_o = tc_q;
    assign rd_data_o  = rd_data_q;
    assign snap_seq_o = snap_seq_q;

endmodule

// File: tb/tb_trig_counter_bank.sv
module tb_trig_counter_bank;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned WIDTH = 32;

    logic                  clk1;
    logic                  reset_n;
    logic [N_CH-1:0]       ch_clear;
    logic [N_CH-1:0]       ch_load;
    logic [WIDTH-1:0]      load_value;
    logic [N_CH-1:0]       ch_up;
    logic [N_CH-1:0]       ch_down;
    logic [2*N_CH-1:0]     ch_mode;
    logic [WIDTH*N_CH-1:0] ch_limit;
    logic                  snap;
    logic [3:0]            rd_ch;
    logic [2:0]            rd_word;
    logic [WIDTH*N_CH-1:0] count;
    logic [N_CH-1:0]       tc_pulse;
    logic [15:0]           rd_data;
    logic [15:0]           snap_seq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned     ch;
        logic [31:0]     cnt;
        logic [N_CH-1:0] tc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] rd_sb[$];

    trig_counter_bank #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .clk1_i       (clk1),
        .reset_n_i    (reset_n),
        .ch_clear_i   (ch_clear),
        .ch_load_i    (ch_load),
        .load_value_i (load_value),
        .ch_up_i      (ch_up),
        .ch_down_i    (ch_down),
        .ch_mode_i    (ch_mode),
        .ch_limit_i   (ch_limit),
        .snap_i       (snap),
        .rd_ch_i      (rd_ch),
        .rd_word_i    (rd_word),
        .count_o      (count),
        .tc_pulse_o   (tc_pulse),
        .rd_data_o    (rd_data),
        .snap_seq_o   (snap_seq)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    function automatic logic [31:0] cnt_of(input int unsigned ch);
        return count[ch*WIDTH +: WIDTH];
    endfunction

    // One edge, then drop all single-cycle pulses; leaves time at edge + 1.
    task automatic tick();
        @(posedge clk1);
        #1;
        ch_clear = '0;
        ch_load  = '0;
        ch_up    = '0;
        ch_down  = '0;
        snap     = 1'b0;
    endtask

    task automatic push(input int unsigned ch, input logic [31:0] c, input logic [N_CH-1:0] t);
        exp_t e;
        e.ch  = ch;
        e.cnt = c;
        e.tc  = t;
        sb.push_back(e);
    endtask

    // Issue one command cycle with its expected result queued, then compare.
    task automatic cmd_check(input string name, input int unsigned ch, input logic [31:0] c,
                             input logic [N_CH-1:0] t);
        exp_t e;
        push(ch, c, t);
        tick();
        e = sb.pop_front();
        checks++;
        if (cnt_of(e.ch) !== e.cnt || tc_pulse !== e.tc) begin
            errors++;
            $display("FAIL %s: count=%h tc=%b, expected count=%h tc=%b",
                     name, cnt_of(e.ch), tc_pulse, e.cnt, e.tc);
        end
    endtask

    task automatic set_mode(input int unsigned ch, input logic [1:0] m);
        ch_mode[2*ch +: 2] = m;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if (count !== '0 || tc_pulse !== '0 || rd_data !== 16'h0 || snap_seq !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold: count=%h rd=%h seq=%h, expected all 0",
                     count, rd_data, snap_seq);
        end
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (count !== '0 || rd_data !== 16'h0 || snap_seq !== 16'h0) begin
            errors++;
            $display("FAIL reset_idle: count=%h rd=%h seq=%h, expected all 0",
                     count, rd_data, snap_seq);
        end
        load_value = 32'd5;
        ch_load[0] = 1'b1;
        cmd_check("reset_load5", 0, 32'd5, 4'b0000);
        reset_n = 1'b0;
        #1;
        checks++;
        if (cnt_of(0) !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: count=%h, expected 0", cnt_of(0));
        end
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        set_mode(0, 2'b00);
        load_value = 32'hFFFF_FFFE;
        ch_load[0] = 1'b1;
        cmd_check("wrap_load", 0, 32'hFFFF_FFFE, 4'b0000);
        ch_up[0] = 1'b1;
        cmd_check("wrap_up1", 0, 32'hFFFF_FFFF, 4'b0000);
        ch_up[0] = 1'b1;
        cmd_check("wrap_up2", 0, 32'h0000_0000, 4'b0001);
        ch_down[0] = 1'b1;
        cmd_check("wrap_down", 0, 32'hFFFF_FFFF, 4'b0001);
        tick();
        checks++;
        if (tc_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL wrap_tc_one_cycle: tc=%b, expected 0000", tc_pulse);
        end
    endtask

    task automatic test_saturate_hold();
        set_mode(1, 2'b01);
        load_value = 32'hFFFF_FFFF;
        ch_load[1] = 1'b1;
        cmd_check("sat_load", 1, 32'hFFFF_FFFF, 4'b0000);
        ch_up[1] = 1'b1;
        cmd_check("sat_up_max", 1, 32'hFFFF_FFFF, 4'b0010);
        ch_clear[1] = 1'b1;
        cmd_check("sat_clear", 1, 32'h0, 4'b0000);
        ch_down[1] = 1'b1;
        cmd_check("sat_down_zero", 1, 32'h0, 4'b0010);
        set_mode(2, 2'b11);
        load_value = 32'd7;
        ch_load[2] = 1'b1;
        cmd_check("hold_load7", 2, 32'd7, 4'b0000);
        ch_up[2] = 1'b1;
        cmd_check("hold_up", 2, 32'd7, 4'b0000);
        load_value = 32'd3;
        ch_load[2] = 1'b1;
        cmd_check("hold_load3", 2, 32'd3, 4'b0000);
    endtask

    task automatic test_modulo();
        set_mode(3, 2'b10);
        ch_limit[3*WIDTH +: WIDTH] = 32'd9;
        ch_clear[3] = 1'b1;
        cmd_check("mod_clear", 3, 32'd0, 4'b0000);
        for (int k = 1; k <= 10; k++) begin
            ch_up[3] = 1'b1;
            cmd_check($sformatf("mod_up%0d", k), 3, (k == 10) ? 32'd0 : 32'(k),
                      (k == 10) ? 4'b1000 : 4'b0000);
        end
        ch_down[3] = 1'b1;
        cmd_check("mod_down_zero", 3, 32'd9, 4'b1000);
        load_value = 32'd20;
        ch_load[3] = 1'b1;
        cmd_check("mod_load20", 3, 32'd20, 4'b0000);
        ch_down[3] = 1'b1;
        cmd_check("mod_down_above", 3, 32'd19, 4'b0000);
        ch_up[3] = 1'b1;
        cmd_check("mod_up_above", 3, 32'd0, 4'b1000);
        ch_limit[3*WIDTH +: WIDTH] = 32'd0;
        ch_up[3] = 1'b1;
        cmd_check("mod_lim0_up", 3, 32'd0, 4'b1000);
        ch_down[3] = 1'b1;
        cmd_check("mod_lim0_down", 3, 32'd0, 4'b1000);
    endtask

    task automatic test_priority();
        set_mode(0, 2'b00);
        load_value  = 32'd55;
        ch_clear[0] = 1'b1;
        ch_load[0]  = 1'b1;
        ch_up[0]    = 1'b1;
        cmd_check("prio_clear", 0, 32'd0, 4'b0000);
        load_value = 32'd4;
        ch_load[0] = 1'b1;
        cmd_check("prio_load4", 0, 32'd4, 4'b0000);
        ch_up[0]   = 1'b1;
        ch_down[0] = 1'b1;
        cmd_check("prio_updown", 0, 32'd4, 4'b0000);
        load_value = 32'd100;
        ch_load[0] = 1'b1;
        ch_up[0]   = 1'b1;
        cmd_check("prio_load_up", 0, 32'd100, 4'b0000);
    endtask

    task automatic read_check(input string name, input logic [3:0] c, input logic [2:0] w,
                              input logic [15:0] exp);
        logic [15:0] e;
        rd_ch   = c;
        rd_word = w;
        rd_sb.push_back(exp);
        tick();
        e = rd_sb.pop_front();
        checks++;
        if (rd_data !== e) begin
            errors++;
            $display("FAIL %s: rd_data=%h, expected %h", name, rd_data, e);
        end
    endtask

    task automatic test_snapshot();
        load_value = 32'h0001_FFFF;
        ch_load[0] = 1'b1;
        cmd_check("snap_load", 0, 32'h0001_FFFF, 4'b0000);
        snap     = 1'b1;
        ch_up[0] = 1'b1;
        cmd_check("snap_live", 0, 32'h0002_0000, 4'b0000);
        checks++;
        if (snap_seq !== 16'd1) begin
            errors++;
            $display("FAIL snap_seq: value=%0d, expected 1", snap_seq);
        end
        read_check("rd_word0", 4'd0, 3'd0, 16'hFFFF);
        read_check("rd_word1", 4'd0, 3'd1, 16'h0001);
        ch_up[0] = 1'b1;
        cmd_check("snap_more_up", 0, 32'h0002_0001, 4'b0000);
        read_check("rd_stable", 4'd0, 3'd0, 16'hFFFF);
        read_check("rd_bad_ch", 4'(N_CH), 3'd0, 16'h0000);
        read_check("rd_bad_word", 4'd0, 3'd2, 16'h0000);
        read_check("rd_ch3_lsw", 4'd3, 3'd0, 16'h0000);
        read_check("rd_ch2_lsw", 4'd2, 3'd0, 16'h0003);
    endtask

    task automatic test_back_to_back();
        ch_clear[0] = 1'b1;
        cmd_check("b2b_clear", 0, 32'd0, 4'b0000);
        for (int k = 1; k <= 3; k++) begin
            ch_up[0] = 1'b1;
            push(0, 32'(k), 4'b0000);
            @(posedge clk1);
            #1;
            begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (cnt_of(e.ch) !== e.cnt || tc_pulse !== e.tc) begin
                    errors++;
                    $display("FAIL b2b_held_up%0d: count=%h tc=%b, expected count=%h tc=%b",
                             k, cnt_of(e.ch), tc_pulse, e.cnt, e.tc);
                end
            end
        end
        ch_up[0] = 1'b0;
        snap = 1'b1;
        tick();
        snap = 1'b1;
        tick();
        checks++;
        if (snap_seq !== 16'd3) begin
            errors++;
            $display("FAIL b2b_snap_seq: value=%0d, expected 3", snap_seq);
        end
        read_check("b2b_rd_ch0", 4'd0, 3'd0, 16'h0003);
    endtask

    initial begin
        reset_n    = 1'b0;
        ch_clear   = '0;
        ch_load    = '0;
        load_value = '0;
        ch_up      = '0;
        ch_down    = '0;
        ch_mode    = '0;
        ch_limit   = '0;
        snap       = 1'b0;
        rd_ch      = '0;
        rd_word    = '0;
        test_reset();
        test_wrap();
        test_saturate_hold();
        test_modulo();
        test_priority();
        test_snapshot();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
